// File: rtl/weight_init_loader_if.sv
// weight_init_loader_if: control and weight-RAM write bus for weight_init_loader.
//   start, pause, rand_in : run control and PN sample stream into the loader
//   we, waddr, wdata      : weight RAM write port driven by the loader
//   busy, done            : run status
//   checksum              : running sum of written weights (WINIT_CHECKSUM_EN only)
// Modports: master = the loader, slave = the environment (sequencer, RAM, bench).
interface weight_init_loader_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              start;
  logic              pause;
  logic [8:0]        rand_in;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;
  logic              busy;
  logic              done;
`ifdef WINIT_CHECKSUM_EN
  logic [15:0]       checksum;

  modport master (
    input  start, pause, rand_in,
    output we, waddr, wdata, busy, done, checksum
  );

  modport slave (
    output start, pause, rand_in,
    input  we, waddr, wdata, busy, done, checksum
  );
`else
  modport master (
    input  start, pause, rand_in,
    output we, waddr, wdata, busy, done
  );

  modport slave (
    output start, pause, rand_in,
    input  we, waddr, wdata, busy, done
  );
`endif
endinterface

// File: rtl/weight_init_loader.sv
// weight_init_loader: on start, converts one PN sample per cycle into a signed
// 8-bit weight and writes NUM_WEIGHTS of them to sequential weight RAM
// addresses, then pulses done.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : weight_init_loader_if.master (start/pause/rand_in in;
//           we/waddr/wdata/busy/done out, all registered)
// Optional feature: define WINIT_CHECKSUM_EN to add the registered 16-bit
// checksum output (sum of sign-extended written weights, cleared on start).
module weight_init_loader #(
  parameter int unsigned NUM_WEIGHTS = 64,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned SHIFT       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  weight_init_loader_if.master bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WEIGHTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef WINIT_CHECKSUM_EN
  logic [15:0]       checksum_q, checksum_d;
`endif

  logic [7:0] centred_c;
  logic [7:0] weight_c;

  // Sample conversion. For x in 256..511, x - 384 equals x[7:0] - 128,
  // which in 8-bit two's complement is x[7:0] with bit 7 inverted.
  // Samples below 256 clamp to -128.
  always_comb begin
    centred_c = bus.rand_in[8] ? {~bus.rand_in[7], bus.rand_in[6:0]} : 8'h80;
    weight_c  = 8'($signed(centred_c) >>> SHIFT);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef WINIT_CHECKSUM_EN
    checksum_d = checksum_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef WINIT_CHECKSUM_EN
          checksum_d = '0;
`endif
        end
      end
      ST_LOAD: begin
        // A paused cycle discards the sample and holds address/data.
        if (!bus.pause) begin
          we_d    = 1'b1;
          waddr_d = cnt_q[ADDR_W-1:0];
          wdata_d = weight_c;
          cnt_d   = cnt_q + CNT_W'(1);
`ifdef WINIT_CHECKSUM_EN
          checksum_d = checksum_q + {{8{weight_c[7]}}, weight_c};
`endif
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef WINIT_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef WINIT_CHECKSUM_EN
      checksum_q <= checksum_d;
`endif
    end
  end

  assign bus.we    = we_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
`ifdef WINIT_CHECKSUM_EN
  assign bus.checksum = checksum_q;
`endif

endmodule

// File: tb/tb_weight_init_loader.sv
// tb_weight_init_loader: directed bench for weight_init_loader.
// dut_a (N=4, SHIFT=0) and dut_b (N=4, SHIFT=2) share stimulus; dut_c (N=64)
// has its own start/reset and covers the full-length run and mid-run reset.
module tb_weight_init_loader;

  logic clk;
  logic reset_ab, reset_c;
  logic start_ab, pause_ab, start_c;
  logic [8:0] rand_in;

  int tests  = 0;
  int failed = 0;
  int sum_a  = 0;
  int sum_b  = 0;
  int sum_c  = 0;

  typedef struct packed {
    logic       we;
    logic [6:0] addr;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];

  weight_init_loader_if #(.ADDR_W(2)) ifa ();
  weight_init_loader_if #(.ADDR_W(2)) ifb ();
  weight_init_loader_if #(.ADDR_W(6)) ifc ();

  assign ifa.start   = start_ab;
  assign ifa.pause   = pause_ab;
  assign ifa.rand_in = rand_in;
  assign ifb.start   = start_ab;
  assign ifb.pause   = pause_ab;
  assign ifb.rand_in = rand_in;
  assign ifc.start   = start_c;
  assign ifc.pause   = 1'b0;
  assign ifc.rand_in = rand_in;

  weight_init_loader #(.NUM_WEIGHTS(4), .ADDR_W(2), .SHIFT(0)) dut_a (
    .clk(clk), .reset(reset_ab), .bus(ifa));
  weight_init_loader #(.NUM_WEIGHTS(4), .ADDR_W(2), .SHIFT(2)) dut_b (
    .clk(clk), .reset(reset_ab), .bus(ifb));
  weight_init_loader #(.NUM_WEIGHTS(64), .ADDR_W(6), .SHIFT(0)) dut_c (
    .clk(clk), .reset(reset_c), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference conversion written in plain integer arithmetic.
  function automatic logic [7:0] model_conv(input int x, input int sh);
    int d;
    d = (x < 256) ? -128 : x - 384;
    d = d >>> sh;
    return 8'(d);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of a/b stimulus, push the expected a/b outputs for the
  // following cycle, advance one edge, then pop and compare.
  task automatic step(input logic st, input logic pse, input int rnd,
                      input logic e_we, input int e_addr,
                      input logic e_busy, input logic e_done);
    exp_t e;
    start_ab = st;
    pause_ab = pse;
    rand_in  = 9'(rnd);
    e.we     = e_we;
    e.addr   = 7'(e_addr);
    e.data_a = model_conv(rnd, 0);
    e.data_b = model_conv(rnd, 2);
    e.busy   = e_busy;
    e.done   = e_done;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("a_we",   32'(ifa.we),   32'(e.we));
    check("a_busy", 32'(ifa.busy), 32'(e.busy));
    check("a_done", 32'(ifa.done), 32'(e.done));
    check("b_we",   32'(ifb.we),   32'(e.we));
    check("b_busy", 32'(ifb.busy), 32'(e.busy));
    check("b_done", 32'(ifb.done), 32'(e.done));
    if (e.we) begin
      check("a_waddr", 32'(ifa.waddr), 32'(e.addr));
      check("a_wdata", 32'(ifa.wdata), 32'(e.data_a));
      check("b_waddr", 32'(ifb.waddr), 32'(e.addr));
      check("b_wdata", 32'(ifb.wdata), 32'(e.data_b));
      sum_a += int'($signed(e.data_a));
      sum_b += int'($signed(e.data_b));
    end
  endtask

  task automatic check_sum_ab();
`ifdef WINIT_CHECKSUM_EN
    check("a_checksum", 32'(ifa.checksum), 32'(16'(sum_a)));
    check("b_checksum", 32'(ifb.checksum), 32'(16'(sum_b)));
`endif
  endtask

  initial begin
    int v2[4];
    int cval;
    v2[0] = 511; v2[1] = 256; v2[2] = 300; v2[3] = 450;

    reset_ab = 1'b1; reset_c = 1'b1;
    start_ab = 1'b0; pause_ab = 1'b0; start_c = 1'b0; rand_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_we",    32'(ifa.we),    32'(0));
    check("rst_a_busy",  32'(ifa.busy),  32'(0));
    check("rst_a_done",  32'(ifa.done),  32'(0));
    check("rst_a_waddr", 32'(ifa.waddr), 32'(0));
    check("rst_a_wdata", 32'(ifa.wdata), 32'(0));
    check("rst_c_waddr", 32'(ifc.waddr), 32'(0));
    reset_ab = 1'b0; reset_c = 1'b0;

    // Pause in IDLE has no effect.
    step(0, 1, 300, 0, 0, 0, 0);

    // Run 1: constant mid-scale sample gives zero weights.
    sum_a = 0; sum_b = 0;
    step(1, 0, 384, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 384, 1, k, 1, 0);
    step(0, 0, 384, 0, 0, 0, 1);
    check_sum_ab();
    step(0, 0, 384, 0, 0, 0, 0);

    // Run 2: start and pause together at E0; pause acts from E1.
    sum_a = 0; sum_b = 0;
    step(1, 1, 511, 0, 0, 1, 0);
    step(0, 1, 511, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) step(0, 0, v2[k], 1, k, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    check_sum_ab();
    step(0, 0, 0, 0, 0, 0, 0);

    // Run 3: clamping, two-cycle pause after second write, start ignored.
    sum_a = 0; sum_b = 0;
    step(1, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 100, 1, 1, 1, 0);
    step(0, 1, 511, 0, 0, 1, 0);
    check("a_pause_waddr", 32'(ifa.waddr), 32'(1));
    check("a_pause_wdata", 32'(ifa.wdata), 32'(8'h80));
    check("b_pause_wdata", 32'(ifb.wdata), 32'(8'hE0));
    step(1, 1, 511, 0, 0, 1, 0);
    check("a_pause2_waddr", 32'(ifa.waddr), 32'(1));
    step(0, 0, 511, 1, 2, 1, 0);
    step(1, 0, 256, 1, 3, 1, 0);
    step(1, 0, 256, 0, 0, 0, 1);
    check_sum_ab();
    step(0, 0, 256, 0, 0, 0, 0);

    // Runs 4 and 5: back-to-back, second start at the earliest edge.
    sum_a = 0; sum_b = 0;
    step(1, 0, 511, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 511, 1, k, 1, 0);
    step(0, 0, 511, 0, 0, 0, 1);
    check_sum_ab();
    sum_a = 0; sum_b = 0;
    step(1, 0, 256, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 256, 1, k, 1, 0);
    step(0, 0, 256, 0, 0, 0, 1);
    check_sum_ab();
    step(0, 0, 256, 0, 0, 0, 0);

    // dut_c: reset after the second write, then a full 64-weight run.
    start_c = 1'b1;
    step(0, 0, 384, 0, 0, 0, 0);
    check("c_start_busy", 32'(ifc.busy), 32'(1));
    check("c_start_we",   32'(ifc.we),   32'(0));
    start_c = 1'b0;
    step(0, 0, 500, 0, 0, 0, 0);
    check("c_w0_we",    32'(ifc.we),    32'(1));
    check("c_w0_waddr", 32'(ifc.waddr), 32'(0));
    check("c_w0_wdata", 32'(ifc.wdata), 32'(model_conv(500, 0)));
    step(0, 0, 260, 0, 0, 0, 0);
    check("c_w1_waddr", 32'(ifc.waddr), 32'(1));
    check("c_w1_wdata", 32'(ifc.wdata), 32'(model_conv(260, 0)));
    reset_c = 1'b1;
    step(0, 0, 384, 0, 0, 0, 0);
    check("c_rst_we",    32'(ifc.we),    32'(0));
    check("c_rst_busy",  32'(ifc.busy),  32'(0));
    check("c_rst_done",  32'(ifc.done),  32'(0));
    check("c_rst_waddr", 32'(ifc.waddr), 32'(0));
    check("c_rst_wdata", 32'(ifc.wdata), 32'(0));
    reset_c = 1'b0;
    step(0, 0, 384, 0, 0, 0, 0);
    check("c_idle_we", 32'(ifc.we), 32'(0));

    sum_c = 0;
    start_c = 1'b1;
    step(0, 0, 384, 0, 0, 0, 0);
    check("c_restart_busy", 32'(ifc.busy), 32'(1));
    start_c = 1'b0;
    for (int k = 0; k < 64; k++) begin
      cval = 256 + 4 * k;
      step(0, 0, cval, 0, 0, 0, 0);
      check("c_run_we",    32'(ifc.we),    32'(1));
      check("c_run_waddr", 32'(ifc.waddr), 32'(k));
      check("c_run_wdata", 32'(ifc.wdata), 32'(model_conv(cval, 0)));
      check("c_run_done",  32'(ifc.done),  32'(0));
      sum_c += int'($signed(model_conv(cval, 0)));
    end
    step(0, 0, 384, 0, 0, 0, 0);
    check("c_done",      32'(ifc.done), 32'(1));
    check("c_done_busy", 32'(ifc.busy), 32'(0));
    check("c_done_we",   32'(ifc.we),   32'(0));
`ifdef WINIT_CHECKSUM_EN
    check("c_checksum", 32'(ifc.checksum), 32'(16'(sum_c)));
`endif
    step(0, 0, 384, 0, 0, 0, 0);
    check("c_done_drop", 32'(ifc.done), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/weight_init_loader.md
# weight_init_loader

Downstream consumer of the PN generator's 9-bit pseudo-random stream. On a start pulse it consumes one random sample per cycle and writes NUM_WEIGHTS signed weights, sequentially addressed, into the network's weight RAM. It then pulses done. Each sample is re-centred to a signed 8-bit value and optionally scaled down by an arithmetic shift, which seeds initial neuron weights before training.

## Interface
- NUM_WEIGHTS, 64, number of weights written per run (≥1).
- ADDR_W, 6, weight RAM address width; 2^ADDR_W ≥ NUM_WEIGHTS.
- SHIFT, 0, arithmetic right shift applied to each weight (0–7).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- start  input  1  begin a run; sampled only in IDLE.
- pause  input  1  while high in LOAD: no write, counter holds, sample discarded.
- rand_in  input  9  PN generator output; nominal range 256–511; treated as valid every cycle.
- we  output  1  weight RAM write enable, registered.
- waddr  output  ADDR_W  write address, registered.
- wdata  output  8  signed weight, registered.
- busy  output  1  high from start acceptance until the done cycle.
- done  output  1  one-cycle pulse after the last write.

## Operation
- States: IDLE, LOAD, DONE.
- IDLE, start=1:
  - Go to LOAD.
  - cnt←0, busy←1.
  - Checksum cleared (when compiled in).
- LOAD, pause=0:
  - we←1, waddr←cnt, wdata←conv(rand_in), cnt←cnt+1.
  - If cnt==NUM_WEIGHTS−1, go to DONE.
- LOAD, pause=1:
  - we←0; cnt, waddr and wdata hold; no transition.
- DONE:
  - we←0, busy←0, done←1, go to IDLE.
- IDLE: we←0, done←0.
- start is ignored in LOAD and DONE; there is no queuing.
- conv(x):
  - If x[8]==0, the sample is out of range: d=−128 (clamp).
  - Otherwise d = x − 384, a signed value in −128..127.
  - wdata = d >>> SHIFT, sign-preserving, 8-bit two's complement.
- cnt is ADDR_W+1 bits wide, so no wrap-around occurs before the terminal compare.
- Reset at any time:
  - State IDLE; we, waddr, wdata, busy, done, cnt and checksum all return to 0.
  - In-flight writes are abandoned, leaving the RAM partially written. No further writes occur.

## Timing
- E0 is the edge that samples start=1 in IDLE. busy rises after E0.
- With no pause, writes k=0..N−1 are registered at E1..EN. we is high for N consecutive cycles, starting one cycle after E0.
- Write data latency: rand_in sampled at edge Ek appears on wdata after Ek, with waddr=k−1. There is one register stage and no combinational path from rand_in to wdata.
- done and busy fall are registered at E(N+1), so done is high (and busy low) for the cycle after E(N+1).
- The next start is accepted at E(N+2) at the earliest.
- Each paused cycle adds exactly one cycle to all subsequent timing.
- pause in IDLE or DONE has no effect.
- start and pause both high at E0: start is accepted; pause takes effect from E1.

## Configuration
- WINIT_CHECKSUM_EN:
  - When defined, adds output port checksum[15:0], registered.
  - checksum is cleared at E0 and on reset.
  - Each write adds sign-extended wdata, modulo 2^16, in the same edge as the write.
  - The value is stable from the done cycle until the next start.
- When not defined, the port and its accumulator are absent; all other behaviour is identical.

## Test plan
- NUM_WEIGHTS=4, SHIFT=0, rand_in held at 384, one-cycle start → we high 4 cycles; waddr 0,1,2,3; wdata 0x00 each; done pulses in the cycle after E5; busy low in that same cycle.
- rand_in sequence 511, 256, 300, 450 → wdata 0x7F, 0x80, 0xAC, 0x42.
- SHIFT=2, rand_in 511 then 256 → wdata 0x1F then 0xE0; rand_in 0 (out of range) → clamped −128 >>> 2 = 0xE0.
- pause high for 2 cycles after the second write (N=4) → we low 2 cycles, waddr holds 1, then addresses 2,3 follow; done is delayed by exactly 2 cycles; second start while busy is ignored.
- reset asserted after the second write (N=64) → next cycle we=0, busy=0, done=0, waddr=0; a new start restarts at address 0.
- WINIT_CHECKSUM_EN, N=4, rand_in 511 → checksum 0x01FC at done; start again with rand_in 256 → checksum 0xFE00.
